kernel_psum_accumulator: RTL and testbench
==========================================

// Module: kernel_psum_accumulator
// PURPOSE
//  Downstream of the kernel-channel PE array. Sums the per-kernel 16-bit psums produced
//  for successive channel groups and kernel taps into ACC_WIDTH-bit totals, one per kernel.
//  Completed NUM_KERNEL-wide results are queued in a small show-ahead FIFO and drained
//  through a valid/ready interface. The PE array cannot stall, so overflows are flagged, not back-pressured.
// PARAMETERS
//  BIT_WIDTH   8   operand width; input psum per kernel is 2*BIT_WIDTH
//  NUM_KERNEL  4   kernels per beat
//  ACC_WIDTH   32  accumulator / output width per kernel
//  CNT_WIDTH   16  width of length/count configuration
//  FIFO_DEPTH  4   output FIFO entries (power of two, >=2)
//  REG_WIDTH   32  error register width
// PORTS
//  clk           in   1                       clock
//  rst           in   1                       synchronous active-high reset
//  i_start       in   1                       1-cycle pulse: latch config, begin job
//  i_acc_len     in   CNT_WIDTH               psum beats summed per output (0 treated as 1)
//  i_out_cnt     in   CNT_WIDTH               outputs in this job
//  i_psum        in   2*BIT_WIDTH*NUM_KERNEL  kernel k at [16k+15:16k], signed
//  i_psum_vld    in   NUM_KERNEL              per-kernel valid from PE array
//  o_data        out  ACC_WIDTH*NUM_KERNEL    FIFO head, kernel k at [ACC_WIDTH*(k+1)-1:ACC_WIDTH*k]
//  o_data_vld    out  1                       FIFO non-empty
//  i_data_rdy    in   1                       downstream accepts head when o_data_vld & i_data_rdy
//  o_busy        out  1                       high while in ST_ACC
//  o_done        out  1                       1-cycle pulse: last output of job pushed
//  err_acc       out  REG_WIDTH               sticky error bits, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state ST_IDLE, accumulators and counters 0.
//  Beat = all i_psum_vld bits high. Partial valid (not all 0, not all 1): err_acc[0]<=1, beat dropped.
//  Arithmetic: each psum sign-extended to ACC_WIDTH, added modulo 2^ACC_WIDTH (wrap, no saturation).
//  States:
//   ST_IDLE: i_start -> latch len=max(i_acc_len,1) and cnt=i_out_cnt, clear acc/beat/out counters.
//            If i_out_cnt==0: o_done pulses next cycle, stay ST_IDLE; else -> ST_ACC.
//            Beat in ST_IDLE: err_acc[2]<=1, ignored.
//   ST_ACC:  each beat: if beat_cnt<len-1, acc+=psum and beat_cnt++.
//            If beat_cnt==len-1: push (acc+psum) to FIFO the same cycle, acc<=0, beat_cnt<=0,
//            out_cnt++. On the cnt-th push: o_done pulses next cycle, -> ST_IDLE.
//   i_start while in ST_ACC: ignored, err_acc[3]<=1.
//  Latency: final beat at cycle T -> o_data_vld high at T+1 if FIFO was empty (no bypass).
//  FIFO: show-ahead. Pop on o_data_vld & i_data_rdy.
//   - Push while full without pop: result dropped, err_acc[1]<=1. Counters still advance.
//   - Push while full with pop in the same cycle: accepted, count unchanged.
//   - Push and pop same cycle when empty: no pop; entry visible next cycle.
//  o_done pulses when the last result is pushed, not when the FIFO drains. FIFO may still hold data in ST_IDLE.
//  Pointers wrap modulo FIFO_DEPTH. Full/empty come from an occupancy counter 0..FIFO_DEPTH.
//  rst mid-job: state, FIFO and accumulators clear within the reset cycle; err_acc clears.
//  err_acc[REG_WIDTH-1:4] stay 0.
// TESTING
//  T1 len=3, cnt=1, three beats with psums k0..k3 = 1,2,3,4 each
//     -> one entry {12,9,6,3} (k3..k0), o_data_vld at T+1, o_done pulse.
//  T2 len=2, cnt=2, k0 psums 16'hFFFF,16'hFFFF,16'h7FFF,16'h0001
//     -> k0 outputs 32'hFFFFFFFE then 32'h00008000 (sign extension).
//  T3 len=1, cnt=6, i_data_rdy=0 -> 4 entries held, 5th and 6th dropped, err_acc[1]=1;
//     then rdy=1 -> exactly 4 pops, in order.
//  T4 i_psum_vld=4'b0111 in ST_ACC -> err_acc[0]=1, beat_cnt unchanged.
//     Beat in ST_IDLE -> err_acc[2]=1.
//  T5 i_start during ST_ACC -> err_acc[3]=1, job continues.
//     rst mid-job -> o_data_vld=0, o_busy=0, err_acc=0 next cycle.
//  T6 i_out_cnt=0 -> o_done pulse next cycle, o_busy never high.
//     i_acc_len=0 -> behaves as len=1.

Source files
------------

// File: rtl/kernel_psum_accumulator.sv
// kernel_psum_accumulator: sums per-kernel psum beats into wide totals
// and queues finished result vectors in a show-ahead output FIFO.
module kernel_psum_accumulator #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [CNT_WIDTH-1:0]              i_acc_len,
  input  logic [CNT_WIDTH-1:0]              i_out_cnt,
  input  logic [2*BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
  input  logic [NUM_KERNEL-1:0]             i_psum_vld,
  output logic [ACC_WIDTH*NUM_KERNEL-1:0]   o_data,
  output logic                              o_data_vld,
  input  logic                              i_data_rdy,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [REG_WIDTH-1:0]              err_acc
);
  localparam int PW = 2 * BIT_WIDTH;
  localparam int DW = ACC_WIDTH * NUM_KERNEL;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [ACC_WIDTH-1:0] acc_q [NUM_KERNEL];
  logic [ACC_WIDTH-1:0] acc_d [NUM_KERNEL];
  logic                 done_q, done_d;
  logic [3:0]           err_q, err_d;
  logic [DW-1:0]        mem_q [FIFO_DEPTH];
  logic [DW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          occ_q, occ_d;

  logic          beat, partial, push, pop, full, push_ok;
  logic [DW-1:0] sum_w;

  // Running total plus the current beat, sign-extended per kernel
  always_comb begin
    sum_w = '0;
    for (int k = 0; k < NUM_KERNEL; k++) begin
      sum_w[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k] +
        {{(ACC_WIDTH-PW){i_psum[k*PW+PW-1]}}, i_psum[k*PW +: PW]};
    end
  end

  // Job control: config latch, beat counting, result push, error flags
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    beat_cnt_d = beat_cnt_q;
    out_cnt_d  = out_cnt_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    err_d      = err_q;
    push       = 1'b0;
    beat       = &i_psum_vld;
    partial    = (|i_psum_vld) & ~beat;
    if (partial) err_d[0] = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (beat) err_d[2] = 1'b1;
        if (i_start) begin
          len_d      = (i_acc_len == '0) ? CNT_WIDTH'(1) : i_acc_len;
          cnt_d      = i_out_cnt;
          beat_cnt_d = '0;
          out_cnt_d  = '0;
          for (int k = 0; k < NUM_KERNEL; k++) acc_d[k] = '0;
          if (i_out_cnt == '0) done_d = 1'b1;
          else                 state_d = ST_ACC;
        end
      end
      default: begin
        if (i_start) err_d[3] = 1'b1;
        if (beat) begin
          if (beat_cnt_q == len_q - CNT_WIDTH'(1)) begin
            push       = 1'b1;
            beat_cnt_d = '0;
            out_cnt_d  = out_cnt_q + CNT_WIDTH'(1);
            for (int k = 0; k < NUM_KERNEL; k++) acc_d[k] = '0;
            if (out_cnt_q + CNT_WIDTH'(1) == cnt_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            for (int k = 0; k < NUM_KERNEL; k++)
              acc_d[k] = sum_w[k*ACC_WIDTH +: ACC_WIDTH];
          end
        end
      end
    endcase
    full    = (occ_q == (AW+1)'(FIFO_DEPTH));
    pop     = (occ_q != '0) & i_data_rdy;
    push_ok = push & (~full | pop);
    if (push & ~push_ok) err_d[1] = 1'b1;
  end

  // Output FIFO: occupancy counter gives full/empty, a full push is dropped
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = sum_w;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      beat_cnt_q <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int k = 0; k < NUM_KERNEL; k++) acc_q[k] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      beat_cnt_q <= beat_cnt_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      acc_q      <= acc_d;
      mem_q      <= mem_d;
    end
  end

  assign o_data     = mem_q[rd_ptr_q];
  assign o_data_vld = (occ_q != '0);
  assign o_busy     = (state_q == ST_ACC);
  assign o_done     = done_q;
  assign err_acc    = {{(REG_WIDTH-4){1'b0}}, err_q};
endmodule

// File: tb/tb_kernel_psum_accumulator.sv
// tb_kernel_psum_accumulator: directed vectors with hand-computed
// expectations for the kernel psum accumulator.
module tb_kernel_psum_accumulator;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [15:0]  i_acc_len;
  logic [15:0]  i_out_cnt;
  logic [63:0]  i_psum;
  logic [3:0]   i_psum_vld;
  logic [127:0] o_data;
  logic         o_data_vld;
  logic         i_data_rdy;
  logic         o_busy;
  logic         o_done;
  logic [31:0]  err_acc;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_err;

  kernel_psum_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_acc_len  (i_acc_len),
    .i_out_cnt  (i_out_cnt),
    .i_psum     (i_psum),
    .i_psum_vld (i_psum_vld),
    .o_data     (o_data),
    .o_data_vld (o_data_vld),
    .i_data_rdy (i_data_rdy),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .err_acc    (err_acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] len, input logic [15:0] cnt);
    i_start   = 1'b1;
    i_acc_len = len;
    i_out_cnt = cnt;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic send(input logic [63:0] p, input logic [3:0] v);
    i_psum     = p;
    i_psum_vld = v;
    tick();
    i_psum_vld = 4'h0;
  endtask

  task automatic pop();
    i_data_rdy = 1'b1;
    tick();
    i_data_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_acc_len = '0; i_out_cnt = '0;
    i_psum = '0; i_psum_vld = '0; i_data_rdy = 1'b0;
    exp_err = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_vld", o_data_vld, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", err_acc, 32'h0);
    chk("rst_data", o_data, 128'h0);

    // T1
    start(16'd3, 16'd1);
    chk("t1_busy", o_busy, 1'b1);
    send({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF);
    send({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF);
    chk("t1_vld_early", o_data_vld, 1'b0);
    send({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF);
    chk("t1_vld", o_data_vld, 1'b1);
    chk("t1_data", o_data, {32'd12, 32'd9, 32'd6, 32'd3});
    chk("t1_done", o_done, 1'b1);
    chk("t1_idle", o_busy, 1'b0);
    tick();
    chk("t1_done_pulse", o_done, 1'b0);
    pop();
    chk("t1_empty", o_data_vld, 1'b0);

    // T2
    start(16'd2, 16'd2);
    send({48'h0, 16'hFFFF}, 4'hF);
    send({48'h0, 16'hFFFF}, 4'hF);
    send({48'h0, 16'h7FFF}, 4'hF);
    send({48'h0, 16'h0001}, 4'hF);
    chk("t2_done", o_done, 1'b1);
    chk("t2_out0", o_data, {96'h0, 32'hFFFFFFFE});
    pop();
    chk("t2_out1", o_data, {96'h0, 32'h00008000});
    chk("t2_vld1", o_data_vld, 1'b1);
    pop();
    chk("t2_empty", o_data_vld, 1'b0);

    // T3
    start(16'd1, 16'd6);
    for (int i = 1; i <= 6; i++) send({48'h0, 16'(i)}, 4'hF);
    exp_err[1] = 1'b1;
    chk("t3_done", o_done, 1'b1);
    chk("t3_err", err_acc, exp_err);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_vld", o_data_vld, 1'b1);
      chk("t3_data", o_data, {96'h0, 32'(i)});
      pop();
    end
    chk("t3_empty", o_data_vld, 1'b0);

    // T4
    start(16'd2, 16'd1);
    send({48'h0, 16'd5}, 4'b0111);
    exp_err[0] = 1'b1;
    chk("t4_partial_err", err_acc, exp_err);
    send({48'h0, 16'd7}, 4'hF);
    chk("t4_no_push", o_data_vld, 1'b0);
    send({48'h0, 16'd1}, 4'hF);
    chk("t4_data", o_data, {96'h0, 32'd8});
    chk("t4_done", o_done, 1'b1);
    pop();
    send({48'h0, 16'd9}, 4'hF);
    exp_err[2] = 1'b1;
    chk("t4_idle_err", err_acc, exp_err);
    chk("t4_idle_vld", o_data_vld, 1'b0);

    // T5
    start(16'd2, 16'd1);
    send({48'h0, 16'd3}, 4'hF);
    start(16'd5, 16'd9);
    exp_err[3] = 1'b1;
    chk("t5_start_err", err_acc, exp_err);
    chk("t5_busy", o_busy, 1'b1);
    send({48'h0, 16'd4}, 4'hF);
    chk("t5_data", o_data, {96'h0, 32'd7});
    chk("t5_done", o_done, 1'b1);
    pop();
    start(16'd2, 16'd2);
    send({48'h0, 16'd9}, 4'hF);
    send({48'h0, 16'd9}, 4'hF);
    chk("t5_pre_vld", o_data_vld, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = '0;
    chk("t5_rst_vld", o_data_vld, 1'b0);
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_err", err_acc, exp_err);

    // T6
    start(16'd4, 16'd0);
    chk("t6_done", o_done, 1'b1);
    chk("t6_busy", o_busy, 1'b0);
    tick();
    chk("t6_done_pulse", o_done, 1'b0);
    chk("t6_busy2", o_busy, 1'b0);
    start(16'd0, 16'd2);
    send({48'h0, 16'd11}, 4'hF);
    chk("t6_len0_vld", o_data_vld, 1'b1);
    chk("t6_len0_d0", o_data, {96'h0, 32'd11});
    send({48'h0, 16'd13}, 4'hF);
    chk("t6_len0_done", o_done, 1'b1);
    pop();
    chk("t6_len0_d1", o_data, {96'h0, 32'd13});
    pop();
    chk("t6_empty", o_data_vld, 1'b0);
    chk("t6_err", err_acc, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
